// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, RV32I funct3 codes,
// FSM state encoding, the captured-request payload and the request legality check.
package lsu_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned MMIO_SEL_BIT = 15;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic              write;
        logic [2:0]        funct3;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } lsu_req_t;

    // Misaligned address or funct3 that has no meaning for this direction.
    function automatic logic req_is_err(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] lane);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = lane[0];
            F3_W:    err = |lane;
            F3_BU:   err = write;
            F3_HU:   err = write | lane[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response handshake of the load/store unit.
// master: core (drives req_*, rsp_ready); slave: load_store_unit.
interface lsu_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic shared by the RAM and MMIO paths.
//   i_word/i_lane/i_funct3 -> o_extract_c : lane extracted and sign/zero extended
//   i_old/i_wdata/i_lane/i_funct3 -> o_merge_c : i_old with the addressed lane(s) replaced
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [1:0]      i_lane,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_extract_c,
    output logic [XLEN-1:0] o_merge_c
);

    logic [4:0]      w_byte_sh;
    logic [4:0]      w_half_sh;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_byte_mask;
    logic [XLEN-1:0] w_half_mask;
    logic [XLEN-1:0] w_byte_data;
    logic [XLEN-1:0] w_half_data;

    // Halfwords are selected by lane[1] only; lane[0] is already an error for H/HU.
    assign w_byte_sh   = {i_lane, 3'b000};
    assign w_half_sh   = {i_lane[1], 4'b0000};
    assign w_byte      = 8'(i_word >> w_byte_sh);
    assign w_half      = 16'(i_word >> w_half_sh);
    assign w_byte_mask = XLEN'(8'hFF) << w_byte_sh;
    assign w_half_mask = XLEN'(16'hFFFF) << w_half_sh;
    assign w_byte_data = XLEN'(i_wdata[7:0]) << w_byte_sh;
    assign w_half_data = XLEN'(i_wdata[15:0]) << w_half_sh;

    // Load extraction
    always_comb begin
        o_extract_c = '0;
        case (i_funct3)
            F3_B:    o_extract_c = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_extract_c = {24'h0, w_byte};
            F3_H:    o_extract_c = {{16{w_half[15]}}, w_half};
            F3_HU:   o_extract_c = {16'h0, w_half};
            F3_W:    o_extract_c = i_word;
            default: o_extract_c = '0;
        endcase
    end

    // Store merge
    always_comb begin
        o_merge_c = i_old;
        case (i_funct3)
            F3_B:    o_merge_c = (i_old & ~w_byte_mask) | w_byte_data;
            F3_H:    o_merge_c = (i_old & ~w_half_mask) | w_half_data;
            F3_W:    o_merge_c = i_wdata;
            default: o_merge_c = i_old;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide RAM with combinational read.
// Loads: IDLE->RD->RESP. SW: IDLE->WR->RESP. SB/SH: IDLE->RD->WR->RESP (read-modify-write).
// Errors (misaligned / illegal funct3): IDLE->RESP with no memory access.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   bus (lsu_if.slave) request/response handshake from the core
//   mem_access_addr    word address to RAM (0 outside RD/WR)
//   mem_in             RAM write data (WR only)
//   mem_write_en       RAM write strobe, forced low while rst_n=0
//   mem_read_en        RAM read enable (RD only)
//   mem_out            RAM read data
//   io_in, io_out      MMIO input port / output register
// Build option: LSU_MMIO_EN -- addr[15]=1 targets io_in/io_out instead of RAM;
// when undefined io_out is 0 and io_in is ignored.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    lsu_if.slave              bus,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [XLEN-1:0]   mem_in,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [XLEN-1:0]   mem_out,
    input  logic [XLEN-1:0]   io_in,
    output logic [XLEN-1:0]   io_out
);

    lsu_state_e      r_state;
    lsu_state_e      w_next_state;
    lsu_req_t        r_req;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_rmw_word;
    logic            r_err;

    logic            w_req_ready;
    logic            w_rsp_valid;
    logic            w_wr_phase;
    logic            w_req_err;
    logic            w_is_mmio;
    logic            w_in_idle;
    logic [XLEN-1:0] w_io_cur;
    logic [XLEN-1:0] w_al_word;
    logic [XLEN-1:0] w_al_old;
    logic [XLEN-1:0] w_al_wdata;
    logic [1:0]      w_al_lane;
    logic [2:0]      w_al_funct3;
    logic [XLEN-1:0] w_extract;
    logic [XLEN-1:0] w_merge;

    assign w_req_err = req_is_err(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
    assign w_in_idle = (r_state == IDLE);

    // In IDLE the aligner serves the MMIO path from the live request; otherwise
    // it serves the RAM path from the captured request.
    assign w_al_word   = w_in_idle ? io_in            : mem_out;
    assign w_al_old    = w_in_idle ? w_io_cur         : r_rmw_word;
    assign w_al_wdata  = w_in_idle ? bus.req_wdata    : r_req.wdata;
    assign w_al_lane   = w_in_idle ? bus.req_addr[1:0] : r_req.addr[1:0];
    assign w_al_funct3 = w_in_idle ? bus.req_funct3   : r_req.funct3;

    lsu_lane_align u_lane_align (
        .i_word      (w_al_word),
        .i_old       (w_al_old),
        .i_wdata     (w_al_wdata),
        .i_lane      (w_al_lane),
        .i_funct3    (w_al_funct3),
        .o_extract_c (w_extract),
        .o_merge_c   (w_merge)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and memory-side outputs
    always_comb begin
        w_next_state    = r_state;
        w_req_ready     = 1'b0;
        w_rsp_valid     = 1'b0;
        w_wr_phase      = 1'b0;
        mem_read_en     = 1'b0;
        mem_access_addr = '0;
        mem_in          = '0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_req_err || w_is_mmio) begin
                        w_next_state = RESP;
                    end else if (bus.req_write && (bus.req_funct3 == F3_W)) begin
                        w_next_state = WR;
                    end else begin
                        w_next_state = RD;
                    end
                end
            end
            RD: begin
                mem_read_en     = 1'b1;
                mem_access_addr = {r_req.addr[ADDR_W-1:2], 2'b00};
                w_next_state    = r_req.write ? WR : RESP;
            end
            WR: begin
                w_wr_phase      = 1'b1;
                mem_access_addr = {r_req.addr[ADDR_W-1:2], 2'b00};
                mem_in          = (r_req.funct3 == F3_W) ? r_req.wdata : w_merge;
                w_next_state    = RESP;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Reset in the WR cycle must not reach the RAM.
    assign mem_write_en = w_wr_phase & rst_n;

    // Request capture and response data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req      <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_rmw_word <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_req   <= lsu_req_t'{write:  bus.req_write,
                                              funct3: bus.req_funct3,
                                              addr:   bus.req_addr,
                                              wdata:  bus.req_wdata};
                        r_err   <= w_req_err;
                        r_rdata <= '0;
                        if (w_is_mmio && !w_req_err && !bus.req_write) begin
                            r_rdata <= w_extract;
                        end
                    end
                end
                RD: begin
                    if (r_req.write) begin
                        r_rmw_word <= mem_out;
                    end else begin
                        r_rdata <= w_extract;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_MMIO_EN
    logic [XLEN-1:0] r_io_out;

    assign w_is_mmio = bus.req_addr[MMIO_SEL_BIT];

    // MMIO stores merge into the output register at the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_io_out <= '0;
        end else if (w_in_idle && bus.req_valid && w_is_mmio && !w_req_err && bus.req_write) begin
            r_io_out <= w_merge;
        end
    end

    assign w_io_cur = r_io_out;
`else
    assign w_is_mmio = 1'b0;
    assign w_io_cur  = '0;
`endif

    assign io_out        = w_io_cur;
    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// requests checked against a byte-addressed reference memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned RAM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_in;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_out;
    logic [31:0] io_in;
    logic [31:0] io_out;

    logic [31:0] ram [RAM_WORDS];
    int          ram_writes = 0;
    logic        bd_en = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;

    logic [7:0]  ref_bytes [256];
    logic [7:0]  io_bytes  [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_if bus();

    load_store_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .mem_access_addr (mem_access_addr),
        .mem_in          (mem_in),
        .mem_write_en    (mem_write_en),
        .mem_read_en     (mem_read_en),
        .mem_out         (mem_out),
        .io_in           (io_in),
        .io_out          (io_out)
    );

    // DataMemory: combinational read, write on the rising edge, plus a bench backdoor.
    assign mem_out = ram[mem_access_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write_en) begin
            ram[mem_access_addr[7:2]] <= mem_in;
            ram_writes <= ram_writes + 1;
        end else if (bd_en) begin
            ram[bd_idx] <= bd_val;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic w, input logic [2:0] f3, input logic [1:0] off);
        int nbytes;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (w && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
        nbytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd2) ? 4 : 2;
        return (int'(off) % nbytes) != 0;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd2) ? 4 : 2;
    endfunction

    function automatic logic [7:0] get_byte(input logic mmio, input logic [31:0] a);
        logic [31:0] t;
        t = io_in >> (8 * int'(a[1:0]));
        return mmio ? t[7:0] : ref_bytes[a[7:0]];
    endfunction

    function automatic logic [31:0] model_load(input logic mmio, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = size_of(f3);
        v = '0;
        for (int k = 0; k < n; k++) begin
            v = v | (32'(get_byte(mmio, a + 32'(k))) << (8 * k));
        end
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {ref_bytes[b + 8'd3], ref_bytes[b + 8'd2], ref_bytes[b + 8'd1], ref_bytes[b]};
    endfunction

    function automatic logic [31:0] io_word();
        return {io_bytes[3], io_bytes[2], io_bytes[1], io_bytes[0]};
    endfunction

    task automatic set_word(input int idx, input logic [31:0] val);
        bd_idx = 6'(idx);
        bd_val = val;
        bd_en  = 1'b1;
        for (int k = 0; k < 4; k++) ref_bytes[8'(idx * 4 + k)] = 8'(val >> (8 * k));
        @(posedge clk); #1;
        bd_en = 1'b0;
    endtask

    // One full transaction: accept, track strobes until response, hold, handshake.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] got_rdata, output logic [31:0] got_wr);
        logic        mmio, e_err, e_rd, e_wr, saw_rd, saw_wr, bad_addr;
        logic [31:0] e_rdata;
        int          e_lat, lat;

        mmio = 1'b0;
`ifdef LSU_MMIO_EN
        mmio = addr[15];
`endif
        e_err   = model_err(w, f3, addr[1:0]);
        e_rdata = (!e_err && !w) ? model_load(mmio, f3, addr) : 32'h0;
        e_lat   = (e_err || mmio) ? 1 : (w && f3 != 3'd2) ? 3 : 2;
        e_rd    = !e_err && !mmio && !(w && f3 == 3'd2);
        e_wr    = !e_err && !mmio && w;

        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;

        lat = 1; saw_rd = 1'b0; saw_wr = 1'b0; bad_addr = 1'b0; got_wr = '0;
        while (!bus.rsp_valid && lat < 8) begin
            if (mem_read_en) saw_rd = 1'b1;
            if (mem_write_en) begin
                saw_wr = 1'b1;
                got_wr = mem_in;
            end
            if ((mem_read_en || mem_write_en) && mem_access_addr != {addr[31:2], 2'b00}) bad_addr = 1'b1;
            @(posedge clk); #1;
            lat++;
        end

        // Apply the store to the model before comparing the written word.
        if (!e_err && w) begin
            for (int k = 0; k < size_of(f3); k++) begin
                if (mmio) io_bytes[2'(int'(addr[1:0]) + k)] = 8'(wdata >> (8 * k));
                else      ref_bytes[8'(int'(addr[7:0]) + k)] = 8'(wdata >> (8 * k));
            end
        end

        got_rdata = bus.rsp_rdata;
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("latency", 32'(lat), 32'(e_lat));
        check("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        check("rsp_rdata", bus.rsp_rdata, e_rdata);
        check("saw_read_en", 32'(saw_rd), 32'(e_rd));
        check("saw_write_en", 32'(saw_wr), 32'(e_wr));
        check("mem_addr", 32'(bad_addr), 32'd0);
        if (e_wr) check("mem_in_word", got_wr, ref_word(addr));
        check("io_out", io_out, io_word());

        for (int i = 0; i < hold; i++) begin
            bus.req_write = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = '0;
            bus.req_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", bus.rsp_rdata, e_rdata);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            check("hold_strobes", 32'({mem_read_en, mem_write_en}), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] r, wd;
        int          wc0;

        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, wd;
        int          wc0;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        io_in = 32'h0000_F00D;
        for (int k = 0; k < 4; k++) io_bytes[k] = '0;

        // Fill RAM and model while in reset.
        rst_n = 1'b0;
        for (int i = 0; i < int'(RAM_WORDS); i++) set_word(i, $urandom);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_io_out", io_out, 32'd0);
        check("rst_strobes", 32'({mem_read_en, mem_write_en}), 32'd0);
        check("rst_mem_addr", mem_access_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Loads with sign/zero extension.
        set_word(1, 32'h8899_AABB);
        do_req(1'b0, F3_B, 32'h5, 32'h0, 0, r, wd);   check("lb_0x5", r, 32'hFFFF_FFAA);
        do_req(1'b0, F3_BU, 32'h5, 32'h0, 0, r, wd);  check("lbu_0x5", r, 32'h0000_00AA);
        do_req(1'b0, F3_HU, 32'h6, 32'h0, 0, r, wd);  check("lhu_0x6", r, 32'h0000_8899);

        // Sub-word store read-modify-write, then read back.
        set_word(2, 32'h1122_3344);
        do_req(1'b1, F3_B, 32'hA, 32'hEE, 0, r, wd);  check("sb_mem_in", wd, 32'h11EE_3344);
        do_req(1'b0, F3_W, 32'h8, 32'h0, 0, r, wd);   check("lw_0x8", r, 32'h11EE_3344);

        // Error responses.
        do_req(1'b0, F3_W, 32'h6, 32'h0, 0, r, wd);   check("lw_mis_rdata", r, 32'h0);
        do_req(1'b1, F3_H, 32'h3, 32'h1234, 0, r, wd);
        do_req(1'b0, 3'b011, 32'h0, 32'h0, 0, r, wd);

        // Response held back for 5 cycles with a competing request present.
        do_req(1'b0, F3_W, 32'h4, 32'h0, 5, r, wd);   check("held_lw", r, 32'h8899_AABB);

        // Reset in the WR cycle of an SB.
        set_word(3, 32'hCAFE_F00D);
        wc0 = ram_writes;
        bus.req_write = 1'b1; bus.req_funct3 = F3_B; bus.req_addr = 32'hD;
        bus.req_wdata = 32'h55; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort_rd_phase", 32'(mem_read_en), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_we_gated", 32'(mem_write_en), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) io_bytes[k] = '0;
        check("abort_we_idle", 32'(mem_write_en), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_rdata", bus.rsp_rdata, 32'd0);
        check("abort_err", 32'(bus.rsp_err), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_mem_addr", mem_access_addr, 32'd0);
        check("abort_ram_writes", 32'(ram_writes - wc0), 32'd0);
        check("abort_ram_word", ram[3], 32'hCAFE_F00D);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);

        // Address with bit 15 set.
        do_req(1'b1, F3_H, 32'h8002, 32'hBEEF, 0, r, wd);
`ifdef LSU_MMIO_EN
        check("mmio_sh_io_out", io_out, 32'hBEEF_0000);
        do_req(1'b0, F3_H, 32'h8000, 32'h0, 0, r, wd);
        check("mmio_lh", r, 32'hFFFF_F00D);
`else
        check("ram_sh_hi", ram[0] >> 16, 32'h0000_BEEF);
        check("ram_sh_io_out", io_out, 32'd0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            io_in = $urandom;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, $urandom_range(0, 2), r, wd);
        end

        // Final RAM contents against the model.
        for (int i = 0; i < int'(RAM_WORDS); i++) begin
            check("final_ram", ram[i], ref_word(32'(i * 4)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
